fetch_unit: RTL

- PC-holding fetch stage that feeds the combinational next-PC predictor and consumes its result.
- Owns the architectural fetch PC and issues instruction-bus requests.
- Passes each returned instruction word to the predictor and captures the predicted next PC.
- Delivers {pc, instr, pred_pc} to decode through a registered output with a one-entry skid buffer, and handles execute-stage redirects, including discarding an in-flight fetch.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: the fetch stage. It holds the architectural fetch PC, issues
// instruction-bus requests, hands each returned word to the external
// combinational next-PC predictor and captures the predicted PC. Each fetched
// instruction goes to decode as {pc, instr, pred_pc} through a registered
// output stage backed by a one-entry skid buffer. Execute-stage redirects
// flush the output and skid registers, and can discard a fetch that is
// still in flight.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   ireq_valid, ireq_addr    instruction-bus request (address is the PC register)
//   iresp_data_ok, iresp_data  response; completes the outstanding request
//   pred_base_pc, pred_raw_instr  operands sent to the predictor
//   pred_pc                  predicted next PC returned by the predictor
//   redirect_valid, redirect_pc  execute-stage redirect
//   stall                    decode cannot accept this cycle
//   f_valid, f_pc, f_instr, f_pred_pc  registered output to decode
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | just out of reset; no request yet
// FETCH   | request outstanding at pc
// DISCARD | redirected while a request was outstanding; drop its response
// HOLD    | output full and stalled, skid holds the next instruction; no request
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   output logic [63:0] pred_base_pc,
   output logic [31:0] pred_raw_instr,
   input  logic [63:0] pred_pc,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
   output logic        f_valid,
   output logic [63:0] f_pc,
   output logic [31:0] f_instr,
   output logic [63:0] f_pred_pc
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] pc, pc_nxt;
   logic        f_valid_nxt;
   logic [63:0] f_pc_nxt, f_pred_pc_nxt;
   logic [31:0] f_instr_nxt;
   logic [63:0] skid_pc, skid_pc_nxt, skid_pred_pc, skid_pred_pc_nxt;
   logic [31:0] skid_instr, skid_instr_nxt;

   assign ireq_valid     = (state == S_FETCH) || (state == S_DISCARD);
   assign ireq_addr      = pc;
   assign pred_base_pc   = pc;
   assign pred_raw_instr = iresp_data;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         pc           <= RESET_PC;
         f_valid      <= 1'b0;
         f_pc         <= '0;
         f_instr      <= '0;
         f_pred_pc    <= '0;
         skid_pc      <= '0;
         skid_instr   <= '0;
         skid_pred_pc <= '0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         f_valid      <= f_valid_nxt;
         f_pc         <= f_pc_nxt;
         f_instr      <= f_instr_nxt;
         f_pred_pc    <= f_pred_pc_nxt;
         skid_pc      <= skid_pc_nxt;
         skid_instr   <= skid_instr_nxt;
         skid_pred_pc <= skid_pred_pc_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      pc_nxt           = pc;
      f_valid_nxt      = f_valid;
      f_pc_nxt         = f_pc;
      f_instr_nxt      = f_instr;
      f_pred_pc_nxt    = f_pred_pc;
      skid_pc_nxt      = skid_pc;
      skid_instr_nxt   = skid_instr;
      skid_pred_pc_nxt = skid_pred_pc;

      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end

         S_FETCH: begin
            if (redirect_valid) begin
               pc_nxt           = redirect_pc;
               f_valid_nxt      = 1'b0;
               skid_pc_nxt      = '0;
               skid_instr_nxt   = '0;
               skid_pred_pc_nxt = '0;
               // A response arriving in the same cycle closes the request,
               // so there is nothing left to discard.
               state_nxt        = iresp_data_ok ? S_FETCH : S_DISCARD;
            end else if (iresp_data_ok) begin
               pc_nxt = pred_pc;
               if (!f_valid || !stall) begin
                  f_valid_nxt   = 1'b1;
                  f_pc_nxt      = pc;
                  f_instr_nxt   = iresp_data;
                  f_pred_pc_nxt = pred_pc;
               end else begin
                  skid_pc_nxt      = pc;
                  skid_instr_nxt   = iresp_data;
                  skid_pred_pc_nxt = pred_pc;
                  state_nxt        = S_HOLD;
               end
            end else if (!stall) begin
               f_valid_nxt = 1'b0;
            end
         end

         S_DISCARD: begin
            f_valid_nxt = 1'b0;
            if (redirect_valid) begin
               pc_nxt = redirect_pc;
            end
            // The response belongs to the abandoned request; pc already
            // holds the corrected target, so just reissue from it.
            if (iresp_data_ok) begin
               state_nxt = S_FETCH;
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               pc_nxt           = redirect_pc;
               f_valid_nxt      = 1'b0;
               skid_pc_nxt      = '0;
               skid_instr_nxt   = '0;
               skid_pred_pc_nxt = '0;
               state_nxt        = S_FETCH;
            end else if (!stall) begin
               f_valid_nxt   = 1'b1;
               f_pc_nxt      = skid_pc;
               f_instr_nxt   = skid_instr;
               f_pred_pc_nxt = skid_pred_pc;
               state_nxt     = S_FETCH;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
